boron_cipher_cntrl: RTL and testbench

BORON_CIPHER_CNTRL -- requirements
Module: boron_cipher_cntrl

---
 rtl/boron_cipher_cntrl.sv | 177 +++++++++++++++++
 tb/tb_boron_cipher_cntrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/boron_cipher_cntrl.sv
// boron_cipher_cntrl
// ---------------------------------------------------------------------------
// Round controller for an iterative block cipher. It owns the text and key
// registers and sequences an external round-function/key-schedule datapath.
//   Encrypt: IDLE -> ROUND x ROUNDS -> DONE
//   Decrypt: IDLE -> KEYGEN x ROUNDS -> LOAD -> ROUND x ROUNDS -> DONE
//     KEYGEN runs the forward key schedule to reach the last round key.
//     The inverse schedule then walks it back during the rounds.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   start, mode           : request (sampled only in IDLE), 0=enc 1=dec
//   in_text, in_key       : operands, captured on an accepted start
//   next_text, next_key   : results returned by the external datapath
//   cur_text, cur_key     : registers driven to the datapath
//   round_cnt, key_dir    : round index, 0=forward / 1=inverse schedule
//   dec_mode, busy        : latched mode, high whenever not IDLE
//   out_valid, out_ready  : result handshake
//   out_text, out_key     : result, held until the next completion
//   dbg_state             : current FSM state (IDLE=0 KEYGEN=1 LOAD=2
//                           ROUND=3 DONE=4)
//
// Handshake: a result transfers on a clock edge where out_valid and
// out_ready are both 1. out_valid stays high, and out_text/out_key stay
// stable, until that edge. out_ready is ignored while out_valid is 0.
// ---------------------------------------------------------------------------
module boron_cipher_cntrl #(
    parameter  int TEXT_W = 64,
    parameter  int KEY_W  = 80,
    parameter  int ROUNDS = 25,
    localparam int CNT_W  = $clog2(ROUNDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [TEXT_W-1:0] in_text,
    input  logic [KEY_W-1:0]  in_key,
    input  logic [TEXT_W-1:0] next_text,
    input  logic [KEY_W-1:0]  next_key,
    output logic [TEXT_W-1:0] cur_text,
    output logic [KEY_W-1:0]  cur_key,
    output logic [CNT_W-1:0]  round_cnt,
    output logic              key_dir,
    output logic              dec_mode,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TEXT_W-1:0] out_text,
    output logic [KEY_W-1:0]  out_key,
    output logic [2:0]        dbg_state
);

    if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
        $error("boron_cipher_cntrl: KEY_W must be 80 or 128");
    end
    if (ROUNDS < 2) begin : g_bad_rounds
        $error("boron_cipher_cntrl: ROUNDS must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYGEN = 3'd1,
        LOAD   = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(ROUNDS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              state_q, state_d;
    logic [TEXT_W-1:0]   text_q, text_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                key_dir_q, key_dir_d;
    logic                dec_q, dec_d;
    logic                ov_q, ov_d;
    logic [TEXT_W-1:0]   otext_q, otext_d;
    logic [KEY_W-1:0]    okey_q, okey_d;
    logic                last_round;

    // Decrypt counts down from ROUNDS to 1, encrypt counts up to ROUNDS-1.
    assign last_round = dec_q ? (cnt_q == CNT_ONE) : (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        text_d    = text_q;
        key_d     = key_q;
        cnt_d     = cnt_q;
        key_dir_d = key_dir_q;
        dec_d     = dec_q;
        ov_d      = ov_q;
        otext_d   = otext_q;
        okey_d    = okey_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dec_d     = mode;
                    text_d    = in_text;
                    key_d     = in_key;
                    cnt_d     = '0;
                    key_dir_d = 1'b0;
                    state_d   = mode ? KEYGEN : ROUND;
                end
            end
            KEYGEN: begin
                key_d = next_key;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) state_d = LOAD;
            end
            LOAD: begin
                key_dir_d = 1'b1;
                cnt_d     = CNT_TOP;
                state_d   = ROUND;
            end
            ROUND: begin
                text_d = next_text;
                key_d  = next_key;
                cnt_d  = dec_q ? (cnt_q - CNT_ONE) : (cnt_q + CNT_ONE);
                if (last_round) begin
                    otext_d = next_text;
                    okey_d  = next_key;
                    ov_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // start is deliberately not looked at here, even when the
                // handshake completes on the same edge.
                if (out_ready) begin
                    ov_d      = 1'b0;
                    key_dir_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            text_q    <= '0;
            key_q     <= '0;
            cnt_q     <= '0;
            key_dir_q <= 1'b0;
            dec_q     <= 1'b0;
            ov_q      <= 1'b0;
            otext_q   <= '0;
            okey_q    <= '0;
        end else begin
            state_q   <= state_d;
            text_q    <= text_d;
            key_q     <= key_d;
            cnt_q     <= cnt_d;
            key_dir_q <= key_dir_d;
            dec_q     <= dec_d;
            ov_q      <= ov_d;
            otext_q   <= otext_d;
            okey_q    <= okey_d;
        end
    end

    assign cur_text  = text_q;
    assign cur_key   = key_q;
    assign round_cnt = cnt_q;
    assign key_dir   = key_dir_q;
    assign dec_mode  = dec_q;
    assign busy      = (state_q != IDLE);
    assign out_valid = ov_q;
    assign out_text  = otext_q;
    assign out_key   = okey_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_boron_cipher_cntrl.sv
// tb_boron_cipher_cntrl
// Directed bench for boron_cipher_cntrl. Two instances: defaults (64/80/25)
// and a 128-bit-key, 4-round build. Each has a stub datapath:
//   next_text = dec_mode ? cur_text-1 : cur_text+1
//   next_key  = key_dir  ? cur_key-1  : cur_key+1
module tb_boron_cipher_cntrl;

    localparam int TW = 64;
    localparam int KW = 80;
    localparam int R  = 25;
    localparam int CW = $clog2(R + 1);
    localparam int KW2 = 128;
    localparam int R2  = 4;
    localparam int CW2 = $clog2(R2 + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // ---------------- DUT 1 (defaults) ----------------
    logic          start, mode, out_ready;
    logic [TW-1:0] in_text, next_text, cur_text, out_text;
    logic [KW-1:0] in_key, next_key, cur_key, out_key;
    logic [CW-1:0] round_cnt;
    logic          key_dir, dec_mode, busy, out_valid;
    logic [2:0]    dbg_state;

    assign next_text = dec_mode ? cur_text - TW'(1) : cur_text + TW'(1);
    assign next_key  = key_dir  ? cur_key - KW'(1)  : cur_key + KW'(1);

    boron_cipher_cntrl #(.TEXT_W(TW), .KEY_W(KW), .ROUNDS(R)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .in_text(in_text), .in_key(in_key),
        .next_text(next_text), .next_key(next_key),
        .cur_text(cur_text), .cur_key(cur_key), .round_cnt(round_cnt),
        .key_dir(key_dir), .dec_mode(dec_mode), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_text(out_text), .out_key(out_key), .dbg_state(dbg_state)
    );

    // ---------------- DUT 2 (KEY_W=128, ROUNDS=4) ----------------
    logic           start2, mode2, out_ready2;
    logic [TW-1:0]  in_text2, next_text2, cur_text2, out_text2;
    logic [KW2-1:0] in_key2, next_key2, cur_key2, out_key2;
    logic [CW2-1:0] round_cnt2;
    logic           key_dir2, dec_mode2, busy2, out_valid2;
    logic [2:0]     dbg_state2;

    assign next_text2 = dec_mode2 ? cur_text2 - TW'(1) : cur_text2 + TW'(1);
    assign next_key2  = key_dir2  ? cur_key2 - KW2'(1) : cur_key2 + KW2'(1);

    boron_cipher_cntrl #(.TEXT_W(TW), .KEY_W(KW2), .ROUNDS(R2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode2),
        .in_text(in_text2), .in_key(in_key2),
        .next_text(next_text2), .next_key(next_key2),
        .cur_text(cur_text2), .cur_key(cur_key2), .round_cnt(round_cnt2),
        .key_dir(key_dir2), .dec_mode(dec_mode2), .busy(busy2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_text(out_text2), .out_key(out_key2), .dbg_state(dbg_state2)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int inject = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_cur_text"},  cur_text,  0);
        check({pfx, "_cur_key"},   cur_key,   0);
        check({pfx, "_round_cnt"}, round_cnt, 0);
        check({pfx, "_key_dir"},   key_dir,   0);
        check({pfx, "_dec_mode"},  dec_mode,  0);
        check({pfx, "_busy"},      busy,      0);
        check({pfx, "_out_valid"}, out_valid, 0);
        check({pfx, "_out_text"},  out_text,  0);
        check({pfx, "_out_key"},   out_key,   0);
        check({pfx, "_state"},     dbg_state, 0);
    endtask

    // ---------------- driver tasks ----------------
    // Issues a start on DUT 1 and counts edges until out_valid rises.
    task automatic run_op(input logic m, input logic [TW-1:0] t, input logic [KW-1:0] k,
                          output int lat);
        start = 1'b1; mode = m; in_text = t; in_key = k;
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; in_text = '1; in_key = '1;
        lat = 0;
        while (!out_valid && lat < 200) begin
            if (inject != 0) begin
                start = (lat == 5 || lat == 30);
                mode  = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (m && lat == R) begin
                check("load_state", dbg_state, 2);
                check("load_cnt", round_cnt, R);
            end
            if (m && lat == R + 1) check("round_key_dir", key_dir, 1);
            if (m && lat == 2 * R) check("dec_last_cnt", round_cnt, 1);
        end
        check("valid_seen", out_valid, 1);
    endtask

    task automatic finish_op(input logic with_start);
        out_ready = 1'b1; start = with_start; mode = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0; start = 1'b0;
        check("hs_state", dbg_state, 0);
        check("hs_busy", busy, 0);
        check("hs_valid", out_valid, 0);
    endtask

    // ---------------- stimulus ----------------
    int lat;
    logic [TW-1:0] sv_text;
    logic [KW-1:0] sv_key;

    initial begin
        reset = 1'b1; start = 0; mode = 0; in_text = 0; in_key = 0; out_ready = 0;
        start2 = 0; mode2 = 0; in_text2 = 0; in_key2 = 0; out_ready2 = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        check("rst2_busy", busy2, 0);
        check("rst2_valid", out_valid2, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_no_start", dbg_state, 0);

        // Encrypt, defaults
        run_op(1'b0, 64'h10, 80'h0, lat);
        check("enc_lat", lat, 25);
        check("enc_text", out_text, 64'h29);
        check("enc_key", out_key, 80'd25);
        check("enc_done_state", dbg_state, 4);
        check("enc_busy", busy, 1);

        // Backpressure: ten cycles without out_ready
        sv_text = out_text; sv_key = out_key;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid", out_valid, 1);
            check("bp_text", out_text, sv_text);
            check("bp_key", out_key, sv_key);
        end
        finish_op(1'b0);
        check("hold_text", out_text, 64'h29);
        check("hold_key", out_key, 80'd25);

        // Decrypt, defaults
        run_op(1'b1, 64'h100, 80'd7, lat);
        check("dec_lat", lat, 51);
        check("dec_text", out_text, 64'hE7);
        check("dec_key", out_key, 80'd7);
        check("dec_mode", dec_mode, 1);
        finish_op(1'b0);
        check("dec_key_dir_clr", key_dir, 0);

        // Decrypt with stray starts in KEYGEN, ROUND, and DONE+out_ready
        inject = 1;
        run_op(1'b1, 64'h100, 80'd7, lat);
        inject = 0;
        check("inj_lat", lat, 51);
        check("inj_text", out_text, 64'hE7);
        check("inj_key", out_key, 80'd7);
        finish_op(1'b1);
        check("inj_cnt_untouched", round_cnt, 0);

        // Reset in the middle of an encrypt
        start = 1'b1; mode = 1'b0; in_text = 64'h77; in_key = 80'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (round_cnt != CW'(12) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("mid_cnt", round_cnt, 12);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_zero("midrst");
        @(posedge clk); #1;
        check("midrst_no_valid", out_valid, 0);
        run_op(1'b0, 64'h1234, 80'h55, lat);
        check("post_lat", lat, 25);
        check("post_text", out_text, 64'h124D);
        check("post_key", out_key, 80'h6E);
        finish_op(1'b0);

        // KEY_W=128, ROUNDS=4, decrypt
        start2 = 1'b1; mode2 = 1'b1; in_text2 = 64'h500;
        in_key2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        @(posedge clk); #1;
        start2 = 1'b0; in_key2 = '0;
        lat = 0;
        while (!out_valid2 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("k128_valid", out_valid2, 1);
        check("k128_lat", lat, 9);
        check("k128_key", out_key2, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        check("k128_text", out_text2, 64'h4FC);
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        check("k128_idle", busy2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
